// File: rtl/tart_frame_sequencer_if.sv
// Sample stream bundle between the frame sequencer and the correlator.
// The master drives valid/last/data, and the slave returns ready.
interface tart_frame_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             sig_valid;
    logic             sig_ready;
    logic             sig_last;
    logic [WIDTH-1:0] sig_idata;
    logic [WIDTH-1:0] sig_qdata;

    modport master (
        output sig_valid,
        output sig_last,
        output sig_idata,
        output sig_qdata,
        input  sig_ready
    );

    modport slave (
        input  sig_valid,
        input  sig_last,
        input  sig_idata,
        input  sig_qdata,
        output sig_ready
    );
endinterface

// File: rtl/tart_frame_sequencer.sv
// Frame-aligned I/Q sample sequencer with a small skid FIFO toward the correlator.
// Optional macro TART_SEQ_DROPCOUNT_EN adds a saturating dropped-sample counter.
module tart_frame_sequencer #(
    parameter int WIDTH  = 32,
    parameter int LBITS  = 10,
    parameter int ABITS  = 2,
    parameter int FCBITS = 16
) (
    input  logic                 sig_clock,
    input  logic                 reset_n,
    input  logic                 enable_i,
    input  logic [LBITS-1:0]     len_i,
    input  logic                 src_valid_i,
    input  logic [WIDTH-1:0]     src_idata_i,
    input  logic [WIDTH-1:0]     src_qdata_i,
    tart_frame_sequencer_if.master sig,
    output logic                 busy_o,
    output logic [FCBITS-1:0]    frame_count_o,
    output logic                 overflow_o,
    output logic [15:0]          drop_count_o
);

    localparam int DEPTH = 1 << ABITS;
    localparam int EW    = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [LBITS-1:0]  pos_q, pos_d;
    logic [LBITS-1:0]  len_q, len_d;
    logic [ABITS:0]    wr_q, wr_d;
    logic [ABITS:0]    rd_q, rd_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [FCBITS-1:0] fc_q, fc_d;
    logic              ovf_q, ovf_d;

    logic             empty;
    logic             full;
    logic             pop;
    logic             take;
    logic             is_last;
    logic             push;
    logic             drop;
    logic [EW-1:0]    head;
    logic [ABITS-1:0] tail_idx;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[ABITS] != rd_q[ABITS]) &&
                      (wr_q[ABITS-1:0] == rd_q[ABITS-1:0]);
    assign head     = mem_q[rd_q[ABITS-1:0]];
    assign pop      = !empty && sig.sig_ready;
    assign is_last  = (pos_q == len_q);
    assign tail_idx = wr_q[ABITS-1:0] - ABITS'(1);

    assign sig.sig_valid = !empty;
    assign sig.sig_last  = head[EW-1];
    assign sig.sig_idata = head[2*WIDTH-1:WIDTH];
    assign sig.sig_qdata = head[WIDTH-1:0];

    assign busy_o        = (state_q != IDLE) || !empty;
    assign frame_count_o = fc_q;
    assign overflow_o    = ovf_q;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    len_d   = len_i;
                    pos_d   = '0;
                end
            end
            RUN: begin
                take = src_valid_i;
                if (!enable_i) state_d = STOP;
            end
            STOP: begin
                if (enable_i) begin
                    take    = src_valid_i;
                    state_d = RUN;
                end else if (pos_q == '0) begin
                    state_d = IDLE;
                end else begin
                    take = src_valid_i;
                    if (src_valid_i && is_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Position advances even for dropped samples to keep frames time-aligned.
        if (take) begin
            if (is_last) begin
                pos_d = '0;
                len_d = len_i;
            end else begin
                pos_d = pos_q + LBITS'(1);
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        push  = take && (!full || pop);
        drop  = take && full && !pop;
        if (push) begin
            mem_d[wr_q[ABITS-1:0]] = {is_last, src_idata_i, src_qdata_i};
            wr_d = wr_q + (ABITS+1)'(1);
        end
        // A dropped frame end is folded into the tail so the frame still closes.
        if (drop && is_last) mem_d[tail_idx][EW-1] = 1'b1;
        if (pop) rd_d = rd_q + (ABITS+1)'(1);
        fc_d  = fc_q;
        if (pop && head[EW-1]) fc_d = fc_q + FCBITS'(1);
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge sig_clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge sig_clock) begin
        mem_q <= mem_d;
    end

`ifdef TART_SEQ_DROPCOUNT_EN
    logic [15:0] dc_q, dc_d;

    always_comb begin
        dc_d = dc_q;
        if (drop && (dc_q != 16'hFFFF)) dc_d = dc_q + 16'd1;
    end

    always_ff @(posedge sig_clock) begin
        if (!reset_n) dc_q <= '0;
        else          dc_q <= dc_d;
    end

    assign drop_count_o = dc_q;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_tart_frame_sequencer.sv
// Directed bench for tart_frame_sequencer: framing, stop, overflow, reset, length change.
// Expected beats are hand-listed per scenario and compared in order.
module tb_tart_frame_sequencer;

    logic        sig_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [9:0]  len_i = '0;
    logic        src_valid_i = 1'b0;
    logic [31:0] src_idata_i = '0;
    logic [31:0] src_qdata_i = '0;
    logic        busy_o;
    logic [15:0] frame_count_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    tart_frame_sequencer_if #(.WIDTH(32)) sig ();

    tart_frame_sequencer dut (
        .sig_clock     (sig_clock),
        .reset_n       (reset_n),
        .enable_i      (enable_i),
        .len_i         (len_i),
        .src_valid_i   (src_valid_i),
        .src_idata_i   (src_idata_i),
        .src_qdata_i   (src_qdata_i),
        .sig           (sig),
        .busy_o        (busy_o),
        .frame_count_o (frame_count_o),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 sig_clock = ~sig_clock;

`ifdef TART_SEQ_DROPCOUNT_EN
    localparam int DC3 = 2;
    localparam int DC4 = 1;
`else
    localparam int DC3 = 0;
    localparam int DC4 = 0;
`endif

    int total = 0;
    int bad = 0;
    int got_d[$];
    int got_q[$];
    bit got_l[$];
    int exp_d[$];
    bit exp_l[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (sig.sig_valid === 1'b1 && sig.sig_ready === 1'b1) begin
            got_d.push_back(int'(sig.sig_idata));
            got_q.push_back(int'(sig.sig_qdata));
            got_l.push_back(sig.sig_last);
        end
        @(posedge sig_clock);
        #1;
    endtask

    task automatic samp(input int k, input bit en);
        enable_i    = en;
        src_valid_i = 1'b1;
        src_idata_i = k;
        src_qdata_i = ~k;
        tick();
    endtask

    task automatic quiet(input int n);
        src_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic beat(input int k, input bit l);
        exp_d.push_back(k);
        exp_l.push_back(l);
    endtask

    task automatic cmp_beats(input string tag);
        chk({tag, ".n"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s.i%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s.q%0d", tag, i), got_q[i], ~exp_d[i]);
            chk($sformatf("%s.l%0d", tag, i), {31'd0, got_l[i]},
                {31'd0, exp_l[i]});
        end
        got_d.delete();
        got_q.delete();
        got_l.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        enable_i      = 1'b0;
        src_valid_i   = 1'b0;
        sig.sig_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        got_d.delete();
        got_q.delete();
        got_l.delete();
    endtask

    // The sample on the IDLE->RUN edge carries 99 and must never appear.
    task automatic start(input int len);
        len_i       = len[9:0];
        enable_i    = 1'b1;
        src_valid_i = 1'b1;
        src_idata_i = 99;
        src_qdata_i = ~32'd99;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sig.sig_ready = 1'b1;
        do_reset();
        chk("rst.valid", sig.sig_valid, 0);
        chk("rst.last", sig.sig_last, 0);
        chk("rst.busy", busy_o, 0);
        chk("rst.fc", frame_count_o, 0);
        chk("rst.ovf", overflow_o, 0);
        chk("rst.dc", drop_count_o, 0);

        start(3);
        for (int k = 0; k < 12; k++) begin
            samp(k, 1'b1);
            beat(k, (k % 4) == 3);
        end
        enable_i = 1'b0;
        quiet(4);
        chk("t1.fc", frame_count_o, 3);
        chk("t1.ovf", overflow_o, 0);
        chk("t1.busy", busy_o, 0);
        cmp_beats("t1");

        do_reset();
        start(3);
        for (int k = 0; k < 6; k++) samp(k, 1'b1);
        for (int k = 6; k < 10; k++) samp(k, 1'b0);
        quiet(3);
        for (int k = 0; k < 8; k++) beat(k, (k % 4) == 3);
        chk("t2.fc", frame_count_o, 2);
        chk("t2.busy", busy_o, 0);
        cmp_beats("t2");

        do_reset();
        sig.sig_ready = 1'b0;
        start(1);
        for (int k = 0; k < 6; k++) samp(k, 1'b1);
        chk("t3.ovf", overflow_o, 1);
        chk("t3.dc", drop_count_o, DC3);
        chk("t3.valid", sig.sig_valid, 1);
        chk("t3.hold", sig.sig_idata, 0);
        chk("t3.busy", busy_o, 1);
        enable_i      = 1'b0;
        sig.sig_ready = 1'b1;
        quiet(6);
        for (int k = 0; k < 4; k++) beat(k, (k % 2) == 1);
        chk("t3.fc", frame_count_o, 2);
        cmp_beats("t3");

        do_reset();
        sig.sig_ready = 1'b0;
        start(4);
        for (int k = 0; k < 4; k++) samp(k, 1'b1);
        len_i = 10'd1;
        samp(4, 1'b1);
        chk("t4.ovf", overflow_o, 1);
        chk("t4.head", sig.sig_idata, 0);
        sig.sig_ready = 1'b1;
        samp(5, 1'b1);
        samp(6, 1'b0);
        quiet(6);
        beat(0, 0); beat(1, 0); beat(2, 0); beat(3, 1);
        beat(5, 0); beat(6, 1);
        chk("t4.fc", frame_count_o, 2);
        chk("t4.dc", drop_count_o, DC4);
        chk("t4.busy", busy_o, 0);
        cmp_beats("t4");

        sig.sig_ready = 1'b0;
        start(7);
        for (int k = 0; k < 3; k++) samp(k, 1'b1);
        chk("t5.pre_valid", sig.sig_valid, 1);
        chk("t5.pre_fc", frame_count_o, 2);
        reset_n     = 1'b0;
        enable_i    = 1'b0;
        src_valid_i = 1'b0;
        tick();
        chk("t5.valid", sig.sig_valid, 0);
        chk("t5.fc", frame_count_o, 0);
        chk("t5.ovf", overflow_o, 0);
        chk("t5.busy", busy_o, 0);
        chk("t5.dc", drop_count_o, 0);
        reset_n       = 1'b1;
        sig.sig_ready = 1'b1;
        quiet(3);
        chk("t5.post_valid", sig.sig_valid, 0);
        cmp_beats("t5");

        do_reset();
        start(3);
        samp(0, 1'b1);
        samp(1, 1'b1);
        len_i = 10'd7;
        for (int k = 2; k < 12; k++) samp(k, k != 11);
        quiet(4);
        for (int k = 0; k < 12; k++) beat(k, (k == 3) || (k == 11));
        chk("t6.fc", frame_count_o, 2);
        chk("t6.busy", busy_o, 0);
        cmp_beats("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
